// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-port bundle for the shared RAM arbiter
interface ram_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
);
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              init_busy;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_busy,
               ram_address, ram_data, ram_wren
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_busy,
               ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - RAM clear sequencer plus two-requester round-robin access arbiter
module ram_arbiter #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 3,
    parameter int                READ_LAT = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic           clock,
    input  logic           reset,
    ram_arbiter_if.slave   bus
);
    typedef enum logic {ST_INIT, ST_ARB} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                fav1_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                wren_q;
    logic [READ_LAT-1:0] pv_q;
    logic [READ_LAT-1:0] po_q;
    logic                rvalid0_q;
    logic                rvalid1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    logic arb_en;
    logic gnt0_d;
    logic gnt1_d;
    logic rd_issue_d;

    // fav1_q set means requester 1 wins the next conflict
    assign arb_en     = !reset && (state_q == ST_ARB);
    assign gnt0_d     = arb_en && bus.req0 && (!bus.req1 || !fav1_q);
    assign gnt1_d     = arb_en && bus.req1 && (!bus.req0 || fav1_q);
    assign rd_issue_d = (gnt0_d && !bus.wr0) || (gnt1_d && !bus.wr1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            fav1_q    <= 1'b0;
            busy_q    <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            pv_q      <= '0;
            po_q      <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            // owner tag travels alongside the RAM read latency
            pv_q[0] <= rd_issue_d;
            po_q[0] <= gnt1_d;
            for (int i = 1; i < READ_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                po_q[i] <= po_q[i-1];
            end
            rvalid0_q <= pv_q[READ_LAT-1] && !po_q[READ_LAT-1];
            rvalid1_q <= pv_q[READ_LAT-1] &&  po_q[READ_LAT-1];
            if (pv_q[READ_LAT-1] && !po_q[READ_LAT-1]) rdata0_q <= bus.ram_q;
            if (pv_q[READ_LAT-1] &&  po_q[READ_LAT-1]) rdata1_q <= bus.ram_q;

            case (state_q)
                ST_INIT: begin
                    addr_q    <= clr_cnt_q;
                    data_q    <= INIT_VAL;
                    wren_q    <= 1'b1;
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_q <= ST_ARB;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ARB: begin
                    if (gnt0_d) begin
                        addr_q <= bus.addr0;
                        data_q <= bus.wdata0;
                        wren_q <= bus.wr0;
                        fav1_q <= 1'b1;
                    end else if (gnt1_d) begin
                        addr_q <= bus.addr1;
                        data_q <= bus.wdata1;
                        wren_q <= bus.wr1;
                        fav1_q <= 1'b0;
                    end else begin
                        wren_q <= 1'b0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.gnt0        = gnt0_d;
    assign bus.gnt1        = gnt1_d;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.init_busy   = busy_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_data    = data_q;
    assign bus.ram_wren    = wren_q;
endmodule
